// File: rtl/pacman_pkg.sv
// Shared maze constants: move directions, scan FSM states and default grid geometry.
package pacman_pkg;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StLoad    = 2'd1,
        StPresent = 2'd2
    } scan_state_e;

    localparam int unsigned GRID_W_DEF  = 21;
    localparam int unsigned GRID_H_DEF  = 21;
    localparam int unsigned COORD_W_DEF = 5;

endpackage

// File: rtl/entity_position_bank_if.sv
// Game-logic / renderer side of the position bank: write, move, random read and scan port.
interface entity_position_bank_if
    import pacman_pkg::*;
#(
    parameter int unsigned ID_W    = 3,
    parameter int unsigned COORD_W = COORD_W_DEF
);
    logic               soft_home;
    logic               wr_en;
    logic [ID_W-1:0]    wr_id;
    logic [COORD_W-1:0] wr_x;
    logic [COORD_W-1:0] wr_y;
    logic               wr_err;
    logic               mv_en;
    logic [ID_W-1:0]    mv_id;
    logic [1:0]         mv_dir;
    logic [ID_W-1:0]    rd_id;
    logic [COORD_W-1:0] rd_x;
    logic [COORD_W-1:0] rd_y;
    logic               scan_start;
    logic               scan_valid;
    logic               scan_ready;
    logic [ID_W-1:0]    scan_id;
    logic [COORD_W-1:0] scan_x;
    logic [COORD_W-1:0] scan_y;
    logic               scan_last;
    logic               scan_busy;

    modport master (
        output soft_home, wr_en, wr_id, wr_x, wr_y, mv_en, mv_id, mv_dir, rd_id,
               scan_start, scan_ready,
        input  wr_err, rd_x, rd_y, scan_valid, scan_id, scan_x, scan_y, scan_last, scan_busy
    );

    modport slave (
        input  soft_home, wr_en, wr_id, wr_x, wr_y, mv_en, mv_id, mv_dir, rd_id,
               scan_start, scan_ready,
        output wr_err, rd_x, rd_y, scan_valid, scan_id, scan_x, scan_y, scan_last, scan_busy
    );

endinterface

// File: rtl/grid_step.sv
// One-tile step of an (x, y) coordinate in a given direction, wrapping at the grid edges.
module grid_step
    import pacman_pkg::*;
#(
    parameter int unsigned COORD_W = COORD_W_DEF,
    parameter int unsigned GRID_W  = GRID_W_DEF,
    parameter int unsigned GRID_H  = GRID_H_DEF
) (
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [1:0]         dir,
    output logic [COORD_W-1:0] next_x,
    output logic [COORD_W-1:0] next_y
);

    localparam logic [COORD_W-1:0] MAX_X = COORD_W'(GRID_W - 1);
    localparam logic [COORD_W-1:0] MAX_Y = COORD_W'(GRID_H - 1);

    always_comb begin
        next_x = x;
        next_y = y;
        unique case (dir)
            DIR_UP:    next_y = (y == '0)    ? MAX_Y : y - COORD_W'(1);
            DIR_RIGHT: next_x = (x == MAX_X) ? '0    : x + COORD_W'(1);
            DIR_DOWN:  next_y = (y == MAX_Y) ? '0    : y + COORD_W'(1);
            DIR_LEFT:  next_x = (x == '0)    ? MAX_X : x - COORD_W'(1);
            default:   ;
        endcase
    end

endmodule

// File: rtl/entity_position_bank.sv
// Position store for Pacman and the ghosts: absolute writes, wrapped single-step moves,
// level-restart homing and a valid/ready scan stream for the tile renderer.
module entity_position_bank
    import pacman_pkg::*;
#(
    parameter int unsigned NUM_ENT = 5,
    parameter int unsigned ID_W    = 3,
    parameter int unsigned COORD_W = COORD_W_DEF,
    parameter int unsigned GRID_W  = GRID_W_DEF,
    parameter int unsigned GRID_H  = GRID_H_DEF,
    parameter int unsigned HOME_X  = 2,
    parameter int unsigned HOME_Y  = 2
) (
    input logic                   clock_50,
    input logic                   reset_n,
    entity_position_bank_if.slave bus
);

    localparam logic [ID_W-1:0]    LAST_ID = ID_W'(NUM_ENT - 1);
    localparam logic [COORD_W-1:0] MAX_X   = COORD_W'(GRID_W - 1);
    localparam logic [COORD_W-1:0] MAX_Y   = COORD_W'(GRID_H - 1);

    logic [COORD_W-1:0] pos_x_q [NUM_ENT];
    logic [COORD_W-1:0] pos_y_q [NUM_ENT];
    logic [COORD_W-1:0] pos_x_d [NUM_ENT];
    logic [COORD_W-1:0] pos_y_d [NUM_ENT];

    logic [COORD_W-1:0] mv_src_x, mv_src_y, step_x, step_y;
    logic [COORD_W-1:0] rd_x, rd_y, scan_src_x, scan_src_y;
    logic               wr_ok, mv_ok, wr_err_q;

    scan_state_e        state_q;
    logic [ID_W-1:0]    idx_q, scan_id_q;
    logic [COORD_W-1:0] scan_x_q, scan_y_q;
    logic               scan_valid_q, scan_last_q;

    assign wr_ok = (bus.wr_id <= LAST_ID) && (bus.wr_x <= MAX_X) && (bus.wr_y <= MAX_Y);
    // A write to the same entity shadows the move, even if the write itself is rejected.
    assign mv_ok = bus.mv_en && (bus.mv_id <= LAST_ID) && !(bus.wr_en && bus.wr_id == bus.mv_id);

    always_comb begin
        mv_src_x   = '0;
        mv_src_y   = '0;
        rd_x       = '0;
        rd_y       = '0;
        scan_src_x = '0;
        scan_src_y = '0;
        for (int i = 0; i < NUM_ENT; i++) begin
            if (bus.mv_id == ID_W'(i)) begin
                mv_src_x = pos_x_q[i];
                mv_src_y = pos_y_q[i];
            end
            if (bus.rd_id == ID_W'(i)) begin
                rd_x = pos_x_q[i];
                rd_y = pos_y_q[i];
            end
            if (idx_q == ID_W'(i)) begin
                scan_src_x = pos_x_q[i];
                scan_src_y = pos_y_q[i];
            end
        end
    end

    grid_step #(
        .COORD_W (COORD_W),
        .GRID_W  (GRID_W),
        .GRID_H  (GRID_H)
    ) u_grid_step (
        .x      (mv_src_x),
        .y      (mv_src_y),
        .dir    (bus.mv_dir),
        .next_x (step_x),
        .next_y (step_y)
    );

    always_comb begin
        for (int i = 0; i < NUM_ENT; i++) begin
            pos_x_d[i] = pos_x_q[i];
            pos_y_d[i] = pos_y_q[i];
            if (bus.soft_home) begin
                pos_x_d[i] = COORD_W'(HOME_X + i);
                pos_y_d[i] = COORD_W'(HOME_Y);
            end else begin
                if (mv_ok && bus.mv_id == ID_W'(i)) begin
                    pos_x_d[i] = step_x;
                    pos_y_d[i] = step_y;
                end
                if (bus.wr_en && wr_ok && bus.wr_id == ID_W'(i)) begin
                    pos_x_d[i] = bus.wr_x;
                    pos_y_d[i] = bus.wr_y;
                end
            end
        end
    end

    always_ff @(posedge clock_50 or posedge reset_n) begin
        if (reset_n) begin
            for (int i = 0; i < NUM_ENT; i++) begin
                pos_x_q[i] <= COORD_W'(HOME_X + i);
                pos_y_q[i] <= COORD_W'(HOME_Y);
            end
            wr_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_ENT; i++) begin
                pos_x_q[i] <= pos_x_d[i];
                pos_y_q[i] <= pos_y_d[i];
            end
            wr_err_q <= bus.wr_en && !bus.soft_home && !wr_ok;
        end
    end

    // Each entry is snapshotted in LOAD, so updates during PRESENT never disturb the renderer.
    always_ff @(posedge clock_50 or posedge reset_n) begin
        if (reset_n) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            scan_id_q    <= '0;
            scan_x_q     <= '0;
            scan_y_q     <= '0;
            scan_valid_q <= 1'b0;
            scan_last_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.scan_start) begin
                        idx_q   <= '0;
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    scan_id_q    <= idx_q;
                    scan_x_q     <= scan_src_x;
                    scan_y_q     <= scan_src_y;
                    scan_last_q  <= (idx_q == LAST_ID);
                    scan_valid_q <= 1'b1;
                    state_q      <= StPresent;
                end
                StPresent: begin
                    if (bus.scan_ready) begin
                        scan_valid_q <= 1'b0;
                        if (scan_last_q) begin
                            state_q <= StIdle;
                        end else begin
                            idx_q   <= idx_q + ID_W'(1);
                            state_q <= StLoad;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.rd_x       = rd_x;
    assign bus.rd_y       = rd_y;
    assign bus.wr_err     = wr_err_q;
    assign bus.scan_valid = scan_valid_q;
    assign bus.scan_id    = scan_id_q;
    assign bus.scan_x     = scan_x_q;
    assign bus.scan_y     = scan_y_q;
    assign bus.scan_last  = scan_last_q;
    assign bus.scan_busy  = (state_q != StIdle);

endmodule

// File: tb/tb_entity_position_bank.sv
// Directed bench for entity_position_bank; scan entries are checked by a scoreboard monitor.
module tb_entity_position_bank;

    localparam int ID_W    = 3;
    localparam int COORD_W = 5;

    typedef struct {
        int id;
        int x;
        int y;
        int last;
    } scan_exp_t;

    logic      clock_50;
    logic      reset_n;
    scan_exp_t exp_q[$];
    int        n_checks;
    int        n_fail;

    entity_position_bank_if #(.ID_W(ID_W), .COORD_W(COORD_W)) bus ();

    entity_position_bank #(
        .NUM_ENT (5),
        .ID_W    (ID_W),
        .COORD_W (COORD_W),
        .GRID_W  (21),
        .GRID_H  (21),
        .HOME_X  (2),
        .HOME_Y  (2)
    ) dut (
        .clock_50 (clock_50),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    initial clock_50 = 1'b0;
    always #5 clock_50 = ~clock_50;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock_50);
        #1;
    endtask

    task automatic check_pos(input int id, input int ex, input int ey, input string name);
        bus.rd_id = ID_W'(id);
        #1;
        check({name, "_x"}, int'(bus.rd_x), ex);
        check({name, "_y"}, int'(bus.rd_y), ey);
    endtask

    task automatic do_write(input int id, input int x, input int y);
        bus.wr_en = 1'b1;
        bus.wr_id = ID_W'(id);
        bus.wr_x  = COORD_W'(x);
        bus.wr_y  = COORD_W'(y);
        step();
        bus.wr_en = 1'b0;
    endtask

    task automatic do_move(input int id, input int dir);
        bus.mv_en  = 1'b1;
        bus.mv_id  = ID_W'(id);
        bus.mv_dir = 2'(dir);
        step();
        bus.mv_en = 1'b0;
    endtask

    task automatic push_exp(input int id, input int x, input int y, input int last);
        scan_exp_t e;
        e.id   = id;
        e.x    = x;
        e.y    = y;
        e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 10 && !bus.scan_valid; i++) step();
        check("scan_valid_wait", int'(bus.scan_valid), 1);
    endtask

    task automatic accept_one();
        wait_valid();
        bus.scan_ready = 1'b1;
        step();
        bus.scan_ready = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 40 && bus.scan_busy; i++) step();
        check(name, int'(bus.scan_busy), 0);
    endtask

    // Scoreboard: compare each accepted scan beat against the oldest expectation.
    always @(negedge clock_50) begin
        if (!reset_n && bus.scan_valid && bus.scan_ready) begin
            if (exp_q.size() == 0) begin
                check("scan_unexpected_beat", int'(bus.scan_id), -1);
            end else begin
                scan_exp_t e;
                e = exp_q.pop_front();
                check("scan_id", int'(bus.scan_id), e.id);
                check("scan_x", int'(bus.scan_x), e.x);
                check("scan_y", int'(bus.scan_y), e.y);
                check("scan_last", int'(bus.scan_last), e.last);
            end
        end
    end

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        reset_n        = 1'b1;
        bus.soft_home  = 1'b0;
        bus.wr_en      = 1'b0;
        bus.wr_id      = '0;
        bus.wr_x       = '0;
        bus.wr_y       = '0;
        bus.mv_en      = 1'b0;
        bus.mv_id      = '0;
        bus.mv_dir     = '0;
        bus.rd_id      = '0;
        bus.scan_start = 1'b0;
        bus.scan_ready = 1'b0;
        step();
        step();
        reset_n = 1'b0;

        // Reset state
        check_pos(3, 5, 2, "reset_id3");
        for (int i = 0; i < 5; i++) check_pos(i, 2 + i, 2, "reset_home");
        check("reset_busy", int'(bus.scan_busy), 0);
        check("reset_valid", int'(bus.scan_valid), 0);
        check("reset_wr_err", int'(bus.wr_err), 0);
        check("reset_scan_last", int'(bus.scan_last), 0);
        check("reset_scan_x", int'(bus.scan_x), 0);

        // Absolute writes and rejection
        do_write(1, 10, 7);
        check_pos(1, 10, 7, "wr_id1");
        check("wr_ok_no_err", int'(bus.wr_err), 0);
        do_write(1, 21, 7);
        check("wr_err_pulse", int'(bus.wr_err), 1);
        check_pos(1, 10, 7, "wr_reject_x");
        step();
        check("wr_err_once", int'(bus.wr_err), 0);
        do_write(6, 1, 1);
        check("wr_err_bad_id", int'(bus.wr_err), 1);
        do_write(3, 4, 21);
        check("wr_err_bad_y", int'(bus.wr_err), 1);
        check_pos(3, 5, 2, "wr_reject_y");
        check_pos(7, 0, 0, "rd_oob");

        // Wrap-around moves
        do_write(0, 20, 9);
        do_move(0, 1);
        check_pos(0, 0, 9, "wrap_right");
        do_move(0, 3);
        check_pos(0, 20, 9, "wrap_left");
        do_write(2, 4, 0);
        do_move(2, 0);
        check_pos(2, 4, 20, "wrap_up");
        do_move(2, 2);
        check_pos(2, 4, 0, "wrap_down");
        do_move(5, 1);
        check_pos(0, 20, 9, "mv_bad_id");

        // Same-cycle write and move
        bus.wr_en = 1'b1; bus.wr_id = 3'd2; bus.wr_x = 5'd8; bus.wr_y = 5'd8;
        bus.mv_en = 1'b1; bus.mv_id = 3'd2; bus.mv_dir = 2'd1;
        step();
        bus.wr_en = 1'b0; bus.mv_en = 1'b0;
        check_pos(2, 8, 8, "coll_same_id");
        bus.wr_en = 1'b1; bus.wr_id = 3'd2; bus.wr_x = 5'd8; bus.wr_y = 5'd8;
        bus.mv_en = 1'b1; bus.mv_id = 3'd3; bus.mv_dir = 2'd2;
        step();
        bus.wr_en = 1'b0; bus.mv_en = 1'b0;
        check_pos(2, 8, 8, "coll_diff_wr");
        check_pos(3, 5, 3, "coll_diff_mv");

        // soft_home beats writes and suppresses wr_err
        bus.soft_home = 1'b1;
        bus.wr_en = 1'b1; bus.wr_id = 3'd0; bus.wr_x = 5'd15; bus.wr_y = 5'd15;
        step();
        bus.soft_home = 1'b0; bus.wr_en = 1'b0;
        for (int i = 0; i < 5; i++) check_pos(i, 2 + i, 2, "soft_home");
        check("home_wr_err", int'(bus.wr_err), 0);
        bus.soft_home = 1'b1;
        bus.wr_en = 1'b1; bus.wr_id = 3'd0; bus.wr_x = 5'd30; bus.wr_y = 5'd1;
        step();
        bus.soft_home = 1'b0; bus.wr_en = 1'b0;
        check("home_bad_wr_no_err", int'(bus.wr_err), 0);

        // Scan with back-pressure; id0 moves after its snapshot is taken
        for (int i = 0; i < 5; i++) push_exp(i, 2 + i, 2, (i == 4) ? 1 : 0);
        bus.scan_start = 1'b1;
        step();
        bus.scan_start = 1'b0;
        check("scan_busy_load", int'(bus.scan_busy), 1);
        check("scan_bubble", int'(bus.scan_valid), 0);
        step();
        do_move(0, 1);
        for (int i = 0; i < 3; i++) begin
            check("bp_valid", int'(bus.scan_valid), 1);
            check("bp_hold_x", int'(bus.scan_x), 2);
            check("bp_hold_id", int'(bus.scan_id), 0);
            step();
        end
        check_pos(0, 3, 2, "bp_moved");
        bus.scan_ready = 1'b1;
        wait_idle("scan_done");
        bus.scan_ready = 1'b0;
        check("scan_q_drained", exp_q.size(), 0);

        // Reset during PRESENT of id2, then a fresh scan restarts at id0
        push_exp(0, 3, 2, 0);
        push_exp(1, 3, 2, 0);
        bus.scan_start = 1'b1;
        step();
        bus.scan_start = 1'b0;
        accept_one();
        accept_one();
        wait_valid();
        check("pre_reset_id", int'(bus.scan_id), 2);
        #2;
        reset_n = 1'b1;
        #1;
        check("midscan_valid", int'(bus.scan_valid), 0);
        check("midscan_busy", int'(bus.scan_busy), 0);
        @(posedge clock_50);
        #1;
        reset_n = 1'b0;
        check_pos(0, 2, 2, "midscan_home");
        for (int i = 0; i < 5; i++) push_exp(i, 2 + i, 2, (i == 4) ? 1 : 0);
        bus.scan_ready = 1'b1;
        bus.scan_start = 1'b1;
        step();
        bus.scan_start = 1'b0;
        wait_idle("rescan_done");
        bus.scan_ready = 1'b0;
        step();
        check("final_q_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
